// File: rtl/rvb_bmat_arbiter.sv
// Round-robin share of one bmat core between two requesters, one operation in flight; result at accept+CYCLES+2.
// A result is held on the owner's port until its dout_ready; no new grant is made meanwhile.
module rvb_bmat_arbiter #(
  parameter int XLEN   = 64,
  parameter int CYCLES = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            r0_din_valid,
  output logic            r0_din_ready,
  input  logic [XLEN-1:0] r0_din_rs1,
  input  logic [XLEN-1:0] r0_din_rs2,
  input  logic            r0_din_insn30,
  output logic            r0_dout_valid,
  input  logic            r0_dout_ready,
  output logic [XLEN-1:0] r0_dout_rd,
  input  logic            r1_din_valid,
  output logic            r1_din_ready,
  input  logic [XLEN-1:0] r1_din_rs1,
  input  logic [XLEN-1:0] r1_din_rs2,
  input  logic            r1_din_insn30,
  output logic            r1_dout_valid,
  input  logic            r1_dout_ready,
  output logic [XLEN-1:0] r1_dout_rd,
  output logic            core_din_valid,
  input  logic            core_din_ready,
  output logic [XLEN-1:0] core_din_rs1,
  output logic [XLEN-1:0] core_din_rs2,
  output logic            core_din_insn30,
  input  logic            core_dout_valid,
  output logic            core_dout_ready,
  input  logic [XLEN-1:0] core_dout_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              owner, last;
  logic [XLEN-1:0]   op_rs1, op_rs2, res;
  logic              op_x;
  logic              grant0, grant1, res_load;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    grant0          = 1'b0;
    grant1          = 1'b0;
    res_load        = 1'b0;
    core_din_valid  = 1'b0;
    core_dout_ready = 1'b0;
    r0_dout_valid   = 1'b0;
    r1_dout_valid   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester not granted last time wins.
        if (r0_din_valid && r1_din_valid) begin
          grant0 = last;
          grant1 = !last;
        end else begin
          grant0 = r0_din_valid;
          grant1 = r1_din_valid;
        end
        if (grant0 || grant1) state_nxt = ISSUE;
      end
      ISSUE: begin
        core_din_valid  = 1'b1;
        core_dout_ready = 1'b1;
        if (core_din_ready) begin
          if (core_dout_valid) begin
            res_load  = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        core_dout_ready = 1'b1;
        if (core_dout_valid) begin
          res_load  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        r0_dout_valid = !owner;
        r1_dout_valid = owner;
        if (owner ? r1_dout_ready : r0_dout_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner  <= 1'b0;
      last   <= 1'b1;
      op_rs1 <= '0;
      op_rs2 <= '0;
      op_x   <= 1'b0;
      res    <= '0;
    end else begin
      if (grant0 || grant1) begin
        owner  <= grant1;
        last   <= grant1;
        op_rs1 <= grant1 ? r1_din_rs1    : r0_din_rs1;
        op_rs2 <= grant1 ? r1_din_rs2    : r0_din_rs2;
        op_x   <= grant1 ? r1_din_insn30 : r0_din_insn30;
      end
      if (res_load) res <= core_dout_rd;
    end
  end

  assign r0_din_ready    = grant0;
  assign r1_din_ready    = grant1;
  assign core_din_rs1    = op_rs1;
  assign core_din_rs2    = op_rs2;
  assign core_din_insn30 = op_x;
  assign r0_dout_rd      = owner ? '0 : res;
  assign r1_dout_rd      = owner ? res : '0;

  // A multi-cycle core never returns its result in the cycle it accepts an operand.
  assert property (@(posedge clock) disable iff (reset)
    !((CYCLES != 0) && (state == ISSUE) && core_din_ready && core_dout_valid));

endmodule

// File: tb/tb_rvb_bmat_arbiter.sv
// Bench for rvb_bmat_arbiter: behavioural bmat core with run-time latency (0 or 8), vector table,
// directed corner sequences and a randomized run against a transaction-level reference model.
module tb_rvb_bmat_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_din_valid, r0_din_ready, r0_din_insn30, r0_dout_valid, r0_dout_ready;
  logic [63:0] r0_din_rs1, r0_din_rs2, r0_dout_rd;
  logic        r1_din_valid, r1_din_ready, r1_din_insn30, r1_dout_valid, r1_dout_ready;
  logic [63:0] r1_din_rs1, r1_din_rs2, r1_dout_rd;
  logic        core_din_valid, core_din_ready, core_din_insn30, core_dout_valid, core_dout_ready;
  logic [63:0] core_din_rs1, core_din_rs2, core_dout_rd;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rvb_bmat_arbiter #(.XLEN(64), .CYCLES(0)) dut (
    .clock(clock), .reset(reset),
    .r0_din_valid(r0_din_valid), .r0_din_ready(r0_din_ready), .r0_din_rs1(r0_din_rs1),
    .r0_din_rs2(r0_din_rs2), .r0_din_insn30(r0_din_insn30), .r0_dout_valid(r0_dout_valid),
    .r0_dout_ready(r0_dout_ready), .r0_dout_rd(r0_dout_rd),
    .r1_din_valid(r1_din_valid), .r1_din_ready(r1_din_ready), .r1_din_rs1(r1_din_rs1),
    .r1_din_rs2(r1_din_rs2), .r1_din_insn30(r1_din_insn30), .r1_dout_valid(r1_dout_valid),
    .r1_dout_ready(r1_dout_ready), .r1_dout_rd(r1_dout_rd),
    .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
    .core_din_rs1(core_din_rs1), .core_din_rs2(core_din_rs2), .core_din_insn30(core_din_insn30),
    .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready), .core_dout_rd(core_dout_rd)
  );

  // Golden 8x8 bit-matrix product: result byte i, bit j combines row i of a with column j of b.
  function automatic logic [63:0] bmat(input logic [63:0] a, input logic [63:0] b, input logic x);
    logic [63:0] r;
    logic [7:0]  row, col;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      row = a[8*i +: 8];
      for (int j = 0; j < 8; j++) begin
        for (int k = 0; k < 8; k++) col[k] = b[8*k + j];
        r[8*i + j] = x ? ^(row & col) : |(row & col);
      end
    end
    return r;
  endfunction

  // Core model: lat==0 is combinational, otherwise result appears lat cycles after accept.
  logic        cm_busy;
  int          cm_cnt;
  logic [63:0] cm_res;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cm_busy <= 1'b0;
      cm_cnt  <= 0;
      cm_res  <= '0;
    end else if (lat != 0) begin
      if (!cm_busy && core_din_valid) begin
        cm_busy <= 1'b1;
        cm_cnt  <= lat - 1;
        cm_res  <= bmat(core_din_rs1, core_din_rs2, core_din_insn30);
      end else if (cm_busy && cm_cnt != 0) begin
        cm_cnt <= cm_cnt - 1;
      end else if (cm_busy && core_dout_ready) begin
        cm_busy <= 1'b0;
      end
    end
  end
  assign core_din_ready  = (lat == 0) ? core_dout_ready : !cm_busy;
  assign core_dout_valid = (lat == 0) ? core_din_valid : (cm_busy && cm_cnt == 0);
  assign core_dout_rd    = (lat == 0) ? bmat(core_din_rs1, core_din_rs2, core_din_insn30) : cm_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic x);
    if (p == 0) begin
      r0_din_valid = v; r0_din_rs1 = a; r0_din_rs2 = b; r0_din_insn30 = x;
    end else begin
      r1_din_valid = v; r1_din_rs1 = a; r1_din_rs2 = b; r1_din_insn30 = x;
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, 64'({r0_din_ready, r1_din_ready, r0_dout_valid, r1_dout_valid,
                 core_din_valid, core_dout_ready}), 64'd0);
    chk({nm, " data"}, core_din_rs1 | core_din_rs2 | r0_dout_rd | r1_dout_rd, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    r0_dout_ready = 1'b0;
    r1_dout_ready = 1'b0;
    @(negedge clock);
    chk_quiet("reset state");
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Single operation on port p with no competition; checks grant, latency, result, other port.
  task automatic do_op(input int p, input logic [63:0] a, input logic [63:0] b, input logic x,
                       input logic [63:0] exp, input int latency, input string nm);
    bit got, other;
    int t0;
    lat = latency;
    r0_dout_ready = 1'b1;
    r1_dout_ready = 1'b1;
    set_req(p, 1'b1, a, b, x);
    got = 0; t0 = 0; other = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ((p == 0) ? r0_din_ready : r1_din_ready) begin got = 1; t0 = cyc; end
      @(posedge clock); #1;
      if (got) break;
    end
    set_req(p, 1'b0, '0, '0, 1'b0);
    chk({nm, " grant"}, 64'(got), 64'd1);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((p == 0) ? r1_dout_valid : r0_dout_valid) other = 1;
      if ((p == 0) ? r0_dout_valid : r1_dout_valid) begin got = 1; break; end
      @(posedge clock); #1;
    end
    chk({nm, " dout_valid"}, 64'(got), 64'd1);
    chk({nm, " latency"}, 64'(cyc - t0), 64'(2 + latency));
    chk({nm, " rd"}, (p == 0) ? r0_dout_rd : r1_dout_rd, exp);
    chk({nm, " other port quiet"}, 64'(other), 64'd0);
    @(posedge clock); #1;
  endtask

  // Reference model state for the randomized run: one transaction outstanding at most.
  bit          m_busy, m_last, m_owner;
  logic [63:0] m_exp;
  int          m_gcyc;

  task automatic rand_phase(input int nops, input int latency, input int budget);
    int  issued, done;
    bit  er0, er1, edv;
    lat = latency;
    issued = 0; done = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      if (issued < nops) begin
        set_req(0, 1'($urandom_range(0, 9) < 6), {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)));
        set_req(1, 1'($urandom_range(0, 9) < 6), {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)));
      end else begin
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
      end
      r0_dout_ready = 1'($urandom_range(0, 9) < 7);
      r1_dout_ready = 1'($urandom_range(0, 9) < 7);
      @(negedge clock);
      er0 = 0; er1 = 0;
      if (!m_busy) begin
        if (r0_din_valid && r1_din_valid) begin er0 = m_last; er1 = !m_last; end
        else begin er0 = r0_din_valid; er1 = r1_din_valid; end
      end
      chk("rand din_ready", 64'({r1_din_ready, r0_din_ready}), 64'({er1, er0}));
      edv = m_busy && (cyc - m_gcyc >= 2 + lat);
      if (m_owner) begin
        chk("rand r1 dout_valid", 64'(r1_dout_valid), 64'(edv));
        chk("rand r0 idle port", 64'(r0_dout_valid) | r0_dout_rd, 64'd0);
        if (edv) chk("rand r1 rd", r1_dout_rd, m_exp);
        if (edv && r1_dout_ready) begin m_busy = 0; done++; end
      end else begin
        chk("rand r0 dout_valid", 64'(r0_dout_valid), 64'(edv));
        chk("rand r1 idle port", 64'(r1_dout_valid) | r1_dout_rd, 64'd0);
        if (edv) chk("rand r0 rd", r0_dout_rd, m_exp);
        if (edv && r0_dout_ready) begin m_busy = 0; done++; end
      end
      if (er0 || er1) begin
        m_busy  = 1;
        m_owner = er1;
        m_last  = er1;
        m_gcyc  = cyc;
        m_exp   = er1 ? bmat(r1_din_rs1, r1_din_rs2, r1_din_insn30)
                      : bmat(r0_din_rs1, r0_din_rs2, r0_din_insn30);
        issued++;
      end
      if (issued >= nops && !m_busy) break;
    end
    chk($sformatf("rand ops completed (lat %0d)", latency), 64'(done), 64'(nops));
  endtask

  typedef struct packed {
    logic r0v, r1v, r0dr, r1dr, e0r, e1r, e0v, e1v;
  } vec_t;

  localparam logic [63:0] A0 = 64'h0123456789ABCDEF, B0 = 64'hFEDCBA9876543210;
  localparam logic [63:0] A1 = 64'hA5A55A5AF00F0FF0, B1 = 64'h1122334455667788;
  localparam logic [63:0] A2 = 64'h00FF00FF12345678, B2 = 64'h8888444422221111;

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [63:0] held, g0, g1;
    bit          got, stable, seen;

    // Four ops per requester with both always valid, then mixed stalls, drops and single requests.
    for (int k = 0; k < 8; k++) begin
      tbl.push_back({4'b1111, (k % 2 == 0) ? 2'b10 : 2'b01, 2'b00});
      tbl.push_back({4'b1111, 2'b00, 2'b00});
      tbl.push_back({4'b1111, 2'b00, (k % 2 == 0) ? 2'b10 : 2'b01});
    end
    tbl.push_back(vec_t'(8'b1111_1000));
    tbl.push_back(vec_t'(8'b1111_0000));
    tbl.push_back(vec_t'(8'b0001_0010));
    tbl.push_back(vec_t'(8'b1101_0010));
    tbl.push_back(vec_t'(8'b0010_0010));
    tbl.push_back(vec_t'(8'b0011_0000));
    tbl.push_back(vec_t'(8'b0111_0100));
    tbl.push_back(vec_t'(8'b0011_0000));
    tbl.push_back(vec_t'(8'b0011_0001));
    tbl.push_back(vec_t'(8'b1011_1000));
    tbl.push_back(vec_t'(8'b0011_0000));
    tbl.push_back(vec_t'(8'b0011_0010));
    tbl.push_back(vec_t'(8'b1111_0100));
    tbl.push_back(vec_t'(8'b0011_0000));
    tbl.push_back(vec_t'(8'b0011_0001));
    tbl.push_back(vec_t'(8'b1111_1000));

    lat = 0;
    do_reset();
    g0 = bmat(A0, B0, 1'b1);
    g1 = bmat(A1, B1, 1'b0);
    set_req(0, 1'b0, A0, B0, 1'b1);
    set_req(1, 1'b0, A1, B1, 1'b0);
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      @(posedge clock); #1;
      r0_din_valid  = v.r0v;
      r1_din_valid  = v.r1v;
      r0_dout_ready = v.r0dr;
      r1_dout_ready = v.r1dr;
      @(negedge clock);
      chk($sformatf("vec%0d ready/valid", k),
          64'({r1_din_ready, r0_din_ready, r1_dout_valid, r0_dout_valid}),
          64'({v.e1r, v.e0r, v.e1v, v.e0v}));
      if (v.e0v) begin
        chk($sformatf("vec%0d r0 rd", k), r0_dout_rd, g0);
        chk($sformatf("vec%0d r1 rd", k), r1_dout_rd, 64'd0);
      end
      if (v.e1v) begin
        chk($sformatf("vec%0d r1 rd", k), r1_dout_rd, g1);
        chk($sformatf("vec%0d r0 rd", k), r0_dout_rd, 64'd0);
      end
    end
    @(posedge clock); #1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    r0_dout_ready = 1'b1;
    r1_dout_ready = 1'b1;
    repeat (4) begin @(posedge clock); #1; end

    // Diagonal permutation matrices: the product reproduces rs1.
    do_op(0, 64'h0102040810204080, 64'h8040201008040201, 1'b1, 64'h0102040810204080, 0, "t1 lat0");
    do_op(0, 64'h0102040810204080, 64'h8040201008040201, 1'b1, 64'h0102040810204080, 8, "t1 lat8");
    do_op(0, '1, '1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 0, "t4 bmator ones");
    do_op(0, '1, '1, 1'b1, 64'h0, 0, "t4 bmatxor ones");

    // Result backpressure on r1 while r0 keeps requesting.
    lat = 0;
    r0_dout_ready = 1'b1;
    r1_dout_ready = 1'b0;
    set_req(0, 1'b1, A0, B0, 1'b1);
    set_req(1, 1'b1, A1, B1, 1'b0);
    @(negedge clock);
    chk("bp r1 wins tie after r0", 64'({r1_din_ready, r0_din_ready}), 64'd2);
    @(posedge clock); #1;
    set_req(1, 1'b0, '0, '0, 1'b0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (r1_dout_valid) begin got = 1; break; end
      @(posedge clock); #1;
    end
    chk("bp r1 dout_valid", 64'(got), 64'd1);
    held = r1_dout_rd;
    chk("bp r1 rd", held, g1);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      if (!r1_dout_valid || r1_dout_rd !== held || r0_din_ready || r0_dout_valid) stable = 0;
    end
    chk("bp held 20 cycles", 64'(stable), 64'd1);
    @(posedge clock); #1;
    r1_dout_ready = 1'b1;
    @(negedge clock);
    chk("bp r0 blocked in release cycle", 64'(r0_din_ready), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp r0 granted after release", 64'({r1_din_ready, r0_din_ready}), 64'd1);
    @(posedge clock); #1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (r0_dout_valid) begin got = 1; break; end
      @(posedge clock); #1;
    end
    chk("bp r0 result", got ? r0_dout_rd : 64'hDEAD, g0);
    @(posedge clock); #1;

    // Reset while the 8-cycle core is working.
    lat = 8;
    set_req(0, 1'b1, A2, B2, 1'b1);
    @(negedge clock);
    chk("rst r0 grant", 64'(r0_din_ready), 64'd1);
    @(posedge clock); #1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    @(negedge clock);
    chk("rst issue", 64'(core_din_valid), 64'd1);
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    chk_quiet("rst mid-op outputs");
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (r0_dout_valid || r1_dout_valid) seen = 1;
    end
    chk("rst result discarded", 64'(seen), 64'd0);
    @(posedge clock); #1;
    do_op(1, A1, B1, 1'b1, bmat(A1, B1, 1'b1), 8, "rst r1 after reset");
    set_req(0, 1'b1, A0, B0, 1'b0);
    set_req(1, 1'b1, A1, B1, 1'b0);
    @(negedge clock);
    chk("rst tie after r1 goes to r0", 64'({r1_din_ready, r0_din_ready}), 64'd1);
    @(posedge clock); #1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);

    // Randomized run from a fresh reset.
    lat = 0;
    do_reset();
    m_busy = 0; m_last = 1; m_owner = 0; m_exp = '0; m_gcyc = 0;
    rand_phase(9600, 0, 50000);
    rand_phase(400, 8, 8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1);
  end

endmodule
